// File: rtl/float64_sig_sub_pkg.sv
// Shared float64 field definitions, special constants, FSM encoding and
// helpers used by the magnitude-subtract datapath.
package float64_sig_sub_pkg;

  localparam int EXP_W  = 11;
  localparam int FRAC_W = 52;
  localparam logic [EXP_W-1:0] EXP_MAX     = 11'h7FF;
  localparam logic [63:0]      DEFAULT_NAN = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0]      QUIET_MASK  = 64'h0008_0000_0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_e;

  // Subnormals behave as if their exponent were 1 (no hidden bit).
  function automatic logic [EXP_W-1:0] effExp(input logic [EXP_W-1:0] e);
    return (e == '0) ? 11'd1 : e;
  endfunction

  // Hidden bit lands on bit 62, leaving 10 guard bits below the fraction.
  function automatic logic [63:0] alignSig(input logic [EXP_W-1:0] e,
                                           input logic [FRAC_W-1:0] f);
    return {1'b0, (e != '0), f, 10'b0};
  endfunction

  function automatic logic [6:0] clz64(input logic [63:0] x);
    logic [6:0] n;
    logic       found;
    n     = 7'd64;
    found = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      if (!found && x[i]) begin
        n     = 7'(63 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] shiftRightJam64(input logic [63:0] x,
                                                  input logic [6:0]  cnt);
    logic [63:0] res;
    logic [63:0] lostMask;
    lostMask = ~(64'hFFFF_FFFF_FFFF_FFFF << cnt);
    if (cnt == 7'd0) begin
      res = x;
    end else if (cnt >= 7'd64) begin
      res = {63'b0, |x};
    end else begin
      res = (x >> cnt) | {63'b0, |(x & lostMask)};
    end
    return res;
  endfunction

endpackage

// File: rtl/float64_sig_sub_core.sv
// Combinational |a| - |b| with NaN/infinity handling, normalisation and
// round-to-nearest-even packing, bit-compatible with SoftFloat subFloat64Sigs.
module float64_sig_sub_core
  import float64_sig_sub_pkg::*;
#(
  parameter logic [63:0] DefaultNan = DEFAULT_NAN
) (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic        zSign_i,
  output logic [63:0] z_o
);

  logic [EXP_W-1:0]  expA, expB, bigExp, smallExp, expDiff, packExp;
  logic [FRAC_W-1:0] fracA, fracB;
  logic              aNaN, bNaN, aSnan, aInf, bInf, aBigger, resSign, overflow;
  logic [63:0]       bigSig, smallSig, diffSig, normSig, subSig, sumChk, roundSum, packed64;
  logic [6:0]        jamCnt, shiftCnt;
  logic signed [12:0] zExp, negExp;
  logic [9:0]        roundBits;
  logic [53:0]       mant;

  assign expA  = a_i[62:52];
  assign expB  = b_i[62:52];
  assign fracA = a_i[51:0];
  assign fracB = b_i[51:0];
  assign aNaN  = (expA == EXP_MAX) && (fracA != '0);
  assign bNaN  = (expB == EXP_MAX) && (fracB != '0);
  assign aSnan = aNaN && !fracA[51];
  assign aInf  = (expA == EXP_MAX) && (fracA == '0);
  assign bInf  = (expB == EXP_MAX) && (fracB == '0);

  // Finite datapath first, then the special cases override it by priority.
  always_comb begin
    aBigger  = a_i[62:0] > b_i[62:0];
    resSign  = aBigger ? zSign_i : ~zSign_i;
    bigExp   = aBigger ? effExp(expA) : effExp(expB);
    smallExp = aBigger ? effExp(expB) : effExp(expA);
    bigSig   = aBigger ? alignSig(expA, fracA) : alignSig(expB, fracB);
    smallSig = aBigger ? alignSig(expB, fracB) : alignSig(expA, fracA);
    expDiff  = bigExp - smallExp;
    jamCnt   = (expDiff > 11'd127) ? 7'd127 : expDiff[6:0];
    diffSig  = bigSig - shiftRightJam64(smallSig, jamCnt);
    shiftCnt = clz64(diffSig) - 7'd1;
    normSig  = diffSig << shiftCnt;
    zExp     = $signed({2'b00, bigExp}) - 13'sd1 - $signed({6'b0, shiftCnt});
    sumChk   = normSig + 64'h200;
    overflow = (zExp > 13'sd2045) || ((zExp == 13'sd2045) && sumChk[63]);
    negExp   = -zExp;
    if (zExp < 13'sd0) begin
      subSig  = shiftRightJam64(normSig, negExp[6:0]);
      packExp = '0;
    end else begin
      subSig  = normSig;
      packExp = zExp[10:0];
    end
    roundBits = subSig[9:0];
    roundSum  = subSig + 64'h200;
    mant      = roundSum[63:10];
    if (roundBits == 10'h200) mant[0] = 1'b0;
    if (mant == '0) packExp = '0;
    // Addition lets a rounding carry out of the significand bump the exponent.
    packed64 = {resSign, 63'b0} + {1'b0, packExp, 52'b0} + {10'b0, mant};

    if (aNaN || bNaN) begin
      if (aNaN) z_o = (aSnan && bNaN) ? (b_i | QUIET_MASK) : (a_i | QUIET_MASK);
      else      z_o = b_i | QUIET_MASK;
    end else if (aInf && bInf) begin
      z_o = DefaultNan;
    end else if (aInf) begin
      z_o = {zSign_i, EXP_MAX, 52'b0};
    end else if (bInf) begin
      z_o = {~zSign_i, EXP_MAX, 52'b0};
    end else if (a_i[62:0] == b_i[62:0]) begin
      z_o = 64'h0;
    end else if (overflow) begin
      z_o = {resSign, EXP_MAX, 52'b0};
    end else begin
      z_o = packed64;
    end
  end

endmodule

// File: rtl/float64_sig_sub.sv
// Handshaked wrapper: captures operands on ap_start, waits LATENCY cycles
// through the FSM and presents the registered difference with a done pulse.
module float64_sig_sub
  import float64_sig_sub_pkg::*;
#(
  parameter int          LATENCY     = 3,
  parameter logic [63:0] DEFAULT_NAN = float64_sig_sub_pkg::DEFAULT_NAN
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        zSign,
  output logic [63:0] ap_return,
  input  logic [7:0]  working_key
);

  localparam int CalcLast = (LATENCY > 1) ? LATENCY - 2 : 0;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [63:0] aOp_q, bOp_q, result_q, result_d, coreA, coreB;
  logic        zSign_q, done_q, ready_q, coreZSign, unusedKey;

  assign unusedKey = ^working_key;

  // With a single-cycle latency the result is formed straight from the inputs.
  assign coreA     = (LATENCY == 1) ? a : aOp_q;
  assign coreB     = (LATENCY == 1) ? b : bOp_q;
  assign coreZSign = (LATENCY == 1) ? zSign : zSign_q;

  float64_sig_sub_core #(
    .DefaultNan(DEFAULT_NAN)
  ) u_core (
    .a_i    (coreA),
    .b_i    (coreB),
    .zSign_i(coreZSign),
    .z_o    (result_d)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      aOp_q    <= '0;
      bOp_q    <= '0;
      zSign_q  <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (ap_start) begin
            aOp_q   <= a;
            bOp_q   <= b;
            zSign_q <= zSign;
            cnt_q   <= '0;
            if (LATENCY == 1) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              ready_q  <= 1'b1;
              result_q <= result_d;
            end else begin
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (cnt_q == 16'(CalcLast)) begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            ready_q  <= 1'b1;
            result_q <= result_d;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ap_done   = done_q;
  assign ap_ready  = ready_q;
  assign ap_return = result_q;
  assign ap_idle   = (state_q == ST_IDLE) && !ap_start;

endmodule

// File: tb/tb_float64_sig_sub.sv
// Self-checking bench for float64_sig_sub: vector table through a scoreboard
// plus abort-by-reset and back-to-back start sequences.
module tb_float64_sig_sub;

  localparam int LAT = 3;

  logic        ap_clk      = 1'b0;
  logic        ap_rst_n    = 1'b1;
  logic        ap_start    = 1'b0;
  logic [63:0] a           = '0;
  logic [63:0] b           = '0;
  logic        zSign       = 1'b0;
  logic [7:0]  working_key = '0;
  logic        ap_done, ap_idle, ap_ready;
  logic [63:0] ap_return;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        z;
    logic [7:0]  key;
    logic [63:0] exp;
  } vec_t;

  typedef struct packed {
    logic [63:0] ret;
    logic        ready;
  } obs_t;

  vec_t        vecs[$];
  logic [63:0] expQ[$];
  obs_t        gotQ[$];
  int          compared  = 0;
  int          mismatched = 0;
  int          doneCount = 0;
  logic        prevDone  = 1'b0;

  float64_sig_sub #(
    .LATENCY(LAT)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .ap_start   (ap_start),
    .ap_done    (ap_done),
    .ap_idle    (ap_idle),
    .ap_ready   (ap_ready),
    .a          (a),
    .b          (b),
    .zSign      (zSign),
    .ap_return  (ap_return),
    .working_key(working_key)
  );

  always #5 ap_clk = ~ap_clk;

  // Output monitor: records every done cycle and counts distinct pulses.
  always @(negedge ap_clk) begin
    if (ap_done) gotQ.push_back({ap_return, ap_ready});
    if (ap_done && !prevDone) doneCount++;
    prevDone = ap_done;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic [63:0] va, input logic [63:0] vb, input logic vz,
                        input logic [7:0] vk, input logic [63:0] ve);
    vec_t v;
    v.a = va; v.b = vb; v.z = vz; v.key = vk; v.exp = ve;
    vecs.push_back(v);
  endtask

  // Pops every pending expectation against observed done-cycle results.
  task automatic drainResults();
    obs_t got;
    int   guard;
    while (expQ.size() > 0) begin
      guard = 0;
      while (gotQ.size() == 0 && guard < 50) begin
        @(negedge ap_clk);
        #1;
        guard++;
      end
      if (gotQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL result_timeout: got no ap_done, expected %h", expQ[0]);
        expQ.delete();
      end else begin
        got = gotQ.pop_front();
        checkOutput("ap_return", got.ret, expQ.pop_front());
        checkOutput("ap_ready_with_done", 64'(got.ready), 64'd1);
      end
    end
  endtask

  // Drives one operation, scrambles inputs after acceptance and measures latency.
  task automatic applyStimulus(input vec_t v);
    int lat;
    bit seen;
    @(negedge ap_clk);
    a = v.a; b = v.b; zSign = v.z; working_key = v.key; ap_start = 1'b1;
    expQ.push_back(v.exp);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge ap_clk);
      lat++;
      if (lat == 1) begin
        ap_start    = 1'b0;
        checkOutput("idle_while_busy", 64'(ap_idle), 64'd0);
        a           = {$urandom, $urandom};
        b           = {$urandom, $urandom};
        zSign       = ~zSign;
        working_key = 8'($urandom);
      end
      seen = ap_done;
    end
    checkOutput("done_latency", 64'(lat), 64'(LAT));
    drainResults();
  endtask

  initial begin
    int base;

    addVec(64'h3FF0000000000000, 64'h3FE0000000000000, 1'b0, 8'h00, 64'h3FE0000000000000);
    addVec(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 8'h00, 64'hBFF0000000000000);
    addVec(64'h4008000000000000, 64'h4008000000000000, 1'b1, 8'h00, 64'h0000000000000000);
    addVec(64'h7FF0000000000000, 64'h7FF0000000000000, 1'b0, 8'h00, 64'h7FFFFFFFFFFFFFFF);
    addVec(64'h7FF0000000000000, 64'h3FF0000000000000, 1'b1, 8'h00, 64'hFFF0000000000000);
    addVec(64'h7FF0000000000001, 64'h3FF0000000000000, 1'b0, 8'h00, 64'h7FF8000000000001);
    addVec(64'h3FF0000000000000, 64'h3C90000000000000, 1'b0, 8'h00, 64'h3FF0000000000000);
    addVec(64'h3FF0000000000000, 64'h7FF0000000000000, 1'b0, 8'h00, 64'hFFF0000000000000);
    addVec(64'h3FF0000000000000, 64'h7FF8000000000000, 1'b0, 8'h00, 64'h7FF8000000000000);
    addVec(64'h7FF0000000000001, 64'h7FF8000000000002, 1'b0, 8'h00, 64'h7FF8000000000002);
    addVec(64'h7FF8000000000003, 64'h7FF0000000000004, 1'b0, 8'h00, 64'h7FF8000000000003);
    addVec(64'h8000000000000000, 64'h0000000000000000, 1'b1, 8'h00, 64'h0000000000000000);
    addVec(64'hBFF0000000000000, 64'h3FE0000000000000, 1'b1, 8'h00, 64'hBFE0000000000000);
    addVec(64'h0000000000000003, 64'h0000000000000001, 1'b0, 8'h00, 64'h0000000000000002);
    addVec(64'h0010000000000000, 64'h0000000000000001, 1'b0, 8'h00, 64'h000FFFFFFFFFFFFF);
    addVec(64'h3FF0000000000000, 64'h3CA0000000000000, 1'b0, 8'h00, 64'h3FEFFFFFFFFFFFFF);
    addVec(64'h3FF0000000000000, 64'h3C80000000000000, 1'b0, 8'h00, 64'h3FF0000000000000);
    addVec(64'h3FF0000000000000, 64'h3C98000000000000, 1'b0, 8'h00, 64'h3FEFFFFFFFFFFFFF);
    addVec(64'h4340000000000000, 64'h3FF0000000000000, 1'b0, 8'hFF, 64'h433FFFFFFFFFFFFF);
    addVec(64'h3FF0000000000000, 64'h3FE0000000000000, 1'b0, 8'hFF, 64'h3FE0000000000000);

    #1 ap_rst_n = 1'b0;
    #1;
    checkOutput("reset_done", 64'(ap_done), 64'd0);
    checkOutput("reset_ready", 64'(ap_ready), 64'd0);
    checkOutput("reset_return", ap_return, 64'h0);
    checkOutput("reset_idle", 64'(ap_idle), 64'd1);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Abort: reset asserted while the operation is in CALC.
    @(negedge ap_clk);
    a = 64'h3FF0000000000000; b = 64'h3FE0000000000000; zSign = 1'b0; ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    ap_rst_n = 1'b0;
    #1;
    checkOutput("abort_done", 64'(ap_done), 64'd0);
    checkOutput("abort_idle", 64'(ap_idle), 64'd1);
    checkOutput("abort_return", ap_return, 64'h0);
    base = doneCount;
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (LAT + 3) @(negedge ap_clk);
    #1;
    checkOutput("abort_pulses", 64'(doneCount - base), 64'd0);
    checkOutput("abort_results", 64'(gotQ.size()), 64'd0);

    // Back-to-back: ap_start held high across two operations, key 00 then FF.
    base = doneCount;
    @(negedge ap_clk);
    a = 64'h3FF0000000000000; b = 64'h4000000000000000; zSign = 1'b0;
    working_key = 8'h00; ap_start = 1'b1;
    expQ.push_back(64'hBFF0000000000000);
    expQ.push_back(64'hBFF0000000000000);
    @(negedge ap_clk);
    working_key = 8'hFF;
    repeat (LAT + 1) @(negedge ap_clk);
    ap_start = 1'b0;
    drainResults();
    repeat (2) @(negedge ap_clk);
    #1;
    checkOutput("b2b_pulses", 64'(doneCount - base), 64'd2);
    checkOutput("idle_after_b2b", 64'(ap_idle), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
